// File: rtl/arm_pkg.sv
// Shared defaults for the core's register file: data/address widths and the
// index of the PC pseudo-register (one past the last storage register).
package arm_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;
    localparam int NREGS_DEF  = 15;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set when a producer issues, cleared when its result
// is written back. A new issue beats a same-cycle retirement of the same register.
module regfile_scoreboard
    import arm_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREGS  = NREGS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we3,
    input  logic [ADDR_W-1:0] a3,
    input  logic              we4,
    input  logic [ADDR_W-1:0] a4,
    input  logic              iss_v,
    input  logic [ADDR_W-1:0] iss_a3,
    input  logic              iss_long,
    input  logic [ADDR_W-1:0] iss_a4,
    output logic [NREGS-1:0]  busy
);
    logic [NREGS-1:0] busy_d;

    // Issue/write addresses at or above NREGS never match any index here,
    // so writes to the PC alias and bogus issues fall out naturally.
    always_comb begin
        busy_d = busy;
        for (int i = 0; i < NREGS; i++) begin
            if ((we3 && a3 == ADDR_W'(i)) || (we4 && a4 == ADDR_W'(i)))
                busy_d[i] = 1'b0;
            if (iss_v && (iss_a3 == ADDR_W'(i) || (iss_long && iss_a4 == ADDR_W'(i))))
                busy_d[i] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!reset) busy <= '0;
        else        busy <= busy_d;
    end
endmodule

// File: rtl/regfile_sb.sv
// Register file with two write ports, three write-through-bypassed read ports,
// a PC+8 pseudo-register at index NREGS, and a busy scoreboard for the hazard unit.
module regfile_sb
    import arm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREGS  = NREGS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] ra3,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] rd3,
    input  logic [DATA_W-1:0] r15,
    input  logic              we3,
    input  logic [ADDR_W-1:0] a3,
    input  logic [DATA_W-1:0] wd3,
    input  logic              we4,
    input  logic [ADDR_W-1:0] a4,
    input  logic [DATA_W-1:0] wd4,
    input  logic              iss_v,
    input  logic [ADDR_W-1:0] iss_a3,
    input  logic              iss_long,
    input  logic [ADDR_W-1:0] iss_a4,
    output logic              busy1,
    output logic              busy2,
    output logic              busy3
);
    localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(NREGS);

    logic [DATA_W-1:0] rf [NREGS];
    logic [NREGS-1:0]  busy;
    logic [ADDR_W-1:0] ra    [3];
    logic [DATA_W-1:0] rd    [3];
    logic              bsy   [3];
    logic              hit3  [3];
    logic              hit4  [3];

    // NOTE: the storage is flops rather than a RAM macro, so it can take a
    // full synchronous clear; a RAM-backed version would need a clear sequencer.
    // Port 4 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            if (we3 && a3 < PC_IDX) rf[a3] <= wd3;
            if (we4 && a4 < PC_IDX) rf[a4] <= wd4;
        end
    end

    regfile_scoreboard #(.ADDR_W(ADDR_W), .NREGS(NREGS)) u_sb (
        .clk      (clk),
        .reset    (reset),
        .we3      (we3),
        .a3       (a3),
        .we4      (we4),
        .a4       (a4),
        .iss_v    (iss_v),
        .iss_a3   (iss_a3),
        .iss_long (iss_long),
        .iss_a4   (iss_a4),
        .busy     (busy)
    );

    assign ra[0] = ra1;
    assign ra[1] = ra2;
    assign ra[2] = ra3;

    // NOTE: every output of this block gets a default first so no path
    // through the if/else chain can infer a latch.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            hit3[p] = we3 && (a3 == ra[p]);
            hit4[p] = we4 && (a4 == ra[p]);
            rd[p]   = '0;
            if (ra[p] == PC_IDX)     rd[p] = r15;
            else if (ra[p] > PC_IDX) rd[p] = '0;
            else if (hit4[p])        rd[p] = wd4;
            else if (hit3[p])        rd[p] = wd3;
            else                     rd[p] = rf[ra[p]];
            // A bypassed operand is already available, so it never stalls.
            bsy[p] = (ra[p] < PC_IDX) && !hit3[p] && !hit4[p] && busy[ra[p]];
        end
    end

    assign rd1   = rd[0];
    assign rd2   = rd[1];
    assign rd3   = rd[2];
    assign busy1 = bsy[0];
    assign busy2 = bsy[1];
    assign busy3 = bsy[2];
endmodule
